// File: rtl/instr_memory.sv
// ============================================================================
// Module   : instr_memory
// Purpose  : Word-organised instruction memory with a combinational fetch and an
//            asynchronously reloaded boot image. Optional clocked write port
//            enabled by defining INSTR_MEM_WRITE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_memory #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  output logic [31:0] out,
  output logic        misaligned,
  output logic        out_of_range,
  input  logic        we,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata
);

  localparam logic [31:0] c_BYTES     = 32'(DEPTH * 4);
  localparam int          c_BOOT_LEN  = 6;
  localparam logic [31:0] c_BOOT [c_BOOT_LEN] = '{
    32'h2008_0005, 32'h2009_000A, 32'h0109_5020,
    32'hAC0A_0000, 32'h8C0B_0000, 32'h1000_FFFF
  };

  function automatic logic [31:0] f_boot(input logic [AW-1:0] idx);
    logic [31:0] v;
    v = 32'h0000_0000;
    for (int k = 0; k < c_BOOT_LEN; k++) begin
      if (32'(idx) == 32'(k)) v = c_BOOT[k];
    end
    return v;
  endfunction

  logic [AW-1:0] w_ridx;
  logic [31:0]   w_word;
  logic          w_in_range;

  assign w_ridx     = addr[AW+1:2];
  assign w_in_range = (addr < c_BYTES);

`ifdef INSTR_MEM_WRITE_EN
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] w_widx;
  logic          w_wr_ok;

  assign w_widx  = waddr[AW+1:2];
  // Misaligned or out-of-range writes are dropped rather than aliased onto a word.
  assign w_wr_ok = we && (waddr[1:0] == 2'b00) && (waddr < c_BYTES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= f_boot(AW'(i));
      end
    end else if (w_wr_ok) begin
      r_mem[w_widx] <= wdata;
    end
  end

  assign w_word = r_mem[w_ridx];
`else
  logic w_unused;

  // ROM build: the write port and clock stay on the port list but do nothing.
  assign w_word   = f_boot(w_ridx);
  assign w_unused = &{1'b0, clk, rst, we, waddr, wdata};
`endif

  assign out          = w_in_range ? w_word : 32'h0000_0000;
  assign misaligned   = (addr[1:0] != 2'b00);
  assign out_of_range = ~w_in_range;

endmodule

`default_nettype wire

// File: tb/tb_instr_memory.sv
// ============================================================================
// Module   : tb_instr_memory
// Purpose  : Directed self-checking bench for instr_memory (DEPTH=64).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_memory;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] out;
  logic        misaligned;
  logic        out_of_range;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  int checks;
  int errors;

  logic [31:0] boot [8];

  instr_memory #(.DEPTH(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .out          (out),
    .misaligned   (misaligned),
    .out_of_range (out_of_range),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; waddr = 32'd0; wdata = 32'd0; addr = 32'd0;
    #2;
    checks++;
    if (out !== 32'h2008_0005) begin
      errors++; $display("FAIL reset_out got=%h exp=%h", out, 32'h2008_0005);
    end
    addr = 32'd1;
    #1;
    checks++;
    if (misaligned !== 1'b1 || out_of_range !== 1'b0) begin
      errors++; $display("FAIL reset_flags got=%b%b exp=10", misaligned, out_of_range);
    end
    #9 rst = 1'b0;
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 10; a++) begin
      addr = 32'(a);
      #5;
      checks++;
      if (out !== boot[a/4] || misaligned !== ((a % 4) != 0) || out_of_range !== 1'b0) begin
        errors++;
        $display("FAIL sweep addr=%0d got=%h/%b/%b exp=%h/%b/0", a, out, misaligned,
                 out_of_range, boot[a/4], ((a % 4) != 0));
      end
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] av [6];
    logic [31:0] ev [6];
    logic [1:0]  fv [6];
    av = '{32'd20, 32'd24, 32'd252, 32'd256, 32'd257, 32'hFFFF_FFFC};
    ev = '{32'h1000_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    fv = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b01};
    for (int i = 0; i < 6; i++) begin
      addr = av[i];
      #2;
      checks++;
      if (out !== ev[i] || {misaligned, out_of_range} !== fv[i]) begin
        errors++;
        $display("FAIL bound addr=%h got=%h/%b%b exp=%h/%b", av[i], out, misaligned,
                 out_of_range, ev[i], fv[i]);
      end
    end
  endtask

`ifdef INSTR_MEM_WRITE_EN
  task automatic test_write();
    @(negedge clk);
    we = 1'b1; waddr = 32'd8; wdata = 32'hDEAD_BEEF; addr = 32'd8;
    #1;
    checks++;
    if (out !== 32'h0109_5020) begin
      errors++; $display("FAIL write_before got=%h exp=%h", out, 32'h0109_5020);
    end
    @(posedge clk); #1;
    we = 1'b0;
    checks++;
    if (out !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL write_after got=%h exp=%h", out, 32'hDEAD_BEEF);
    end
    addr = 32'd4; #1;
    checks++;
    if (out !== 32'h2009_000A) begin
      errors++; $display("FAIL write_neighbour got=%h exp=%h", out, 32'h2009_000A);
    end
    addr = 32'd8;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out !== 32'h0109_5020) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", out, 32'h0109_5020);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_during_reset();
    @(negedge clk);
    rst = 1'b1; we = 1'b1; waddr = 32'd8; wdata = 32'h1234_5678; addr = 32'd8;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    #1;
    checks++;
    if (out !== 32'h0109_5020) begin
      errors++; $display("FAIL reset_blocks_write got=%h exp=%h", out, 32'h0109_5020);
    end
  endtask

  task automatic test_dropped_writes();
    @(negedge clk);
    we = 1'b1; waddr = 32'd6; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    waddr = 32'd256;
    @(negedge clk);
    we = 1'b0;
    for (int w = 0; w < 3; w++) begin
      addr = 32'(w * 4);
      #1;
      checks++;
      if (out !== boot[w]) begin
        errors++; $display("FAIL dropped_write word=%0d got=%h exp=%h", w, out, boot[w]);
      end
    end
  endtask
`else
  task automatic test_rom_write();
    @(negedge clk);
    we = 1'b1; waddr = 32'd8; wdata = 32'hDEAD_BEEF; addr = 32'd8;
    @(posedge clk); #1;
    checks++;
    if (out !== 32'h0109_5020) begin
      errors++; $display("FAIL rom_write8 got=%h exp=%h", out, 32'h0109_5020);
    end
    @(negedge clk);
    waddr = 32'd0; addr = 32'd0;
    @(posedge clk); #1;
    we = 1'b0;
    checks++;
    if (out !== 32'h2008_0005) begin
      errors++; $display("FAIL rom_write0 got=%h exp=%h", out, 32'h2008_0005);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    boot = '{32'h2008_0005, 32'h2009_000A, 32'h0109_5020, 32'hAC0A_0000,
             32'h8C0B_0000, 32'h1000_FFFF, 32'h0, 32'h0};
    test_reset();
    test_sweep();
    test_boundaries();
`ifdef INSTR_MEM_WRITE_EN
    test_write();
    test_write_during_reset();
    test_dropped_writes();
`else
    test_rom_write();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
